// File: rtl/gradient_render.sv
// Renders the gradient stream back to RGB video and publishes per-frame edge statistics.
// Optional macro GRADIENT_RENDER_HEATMAP_EN paints non-edge active pixels as a gray heat map.
module gradient_render #(
    parameter int          H_SIZE            = 83,
    parameter logic [16:0] THRESHOLD_DEFAULT = 17'd1024
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic signed [8:0]  gradient_x_in,
    input  logic signed [8:0]  gradient_y_in,
    input  logic [16:0]        squared_modulus_in,
    input  logic [16:0]        threshold,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [7:0]         pixel_r,
    output logic [7:0]         pixel_g,
    output logic [7:0]         pixel_b,
    output logic               frame_done,
    output logic [15:0]        edge_count,
    output logic               line_err
);

    typedef enum logic {WAIT_SYNC, RUN} state_t;

    function automatic logic [8:0] abs9(input logic signed [8:0] v);
        logic [8:0] u;
        u = v;
        return v[8] ? (~u + 9'd1) : u;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    state_t      state_q, state_d;
    logic [16:0] thr_q, thr_d;
    logic        vs_prev_q, de_prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] run_cnt_q, run_cnt_d;
    logic        discard_q, discard_d;
    logic        err_q, err_d;

    logic        de_p1_q, hs_p1_q, vs_p1_q, edge_p1_q, xdom_p1_q;
    logic [7:0]  heat_p1_q, heat_p1_d;
    logic        pub_p1_q, pub_p1_d, perr_p1_q;
    logic [15:0] pcnt_p1_q;

    logic        de_out_q, hs_out_q, vs_out_q;
    logic [23:0] rgb_q, rgb_d;
    logic        frame_done_q, line_err_q, line_err_d;
    logic [15:0] edge_count_q, edge_count_d;

    logic        vs_rise, is_edge, x_dom;
    logic [8:0]  ax, ay;

    always_comb begin
        vs_rise = vsync_in & ~vs_prev_q;
        ax      = abs9(gradient_x_in);
        ay      = abs9(gradient_y_in);
        x_dom   = (ax >= ay);
        is_edge = de_in & (squared_modulus_in >= thr_q);

        state_d = vs_rise ? RUN : state_q;
        thr_d   = vs_rise ? threshold : thr_q;

        // A pixel arriving with the vsync edge is the first pixel of the new frame.
        if (vs_rise)
            cnt_d = {15'd0, is_edge};
        else if (state_q == RUN && is_edge)
            cnt_d = sat_inc16(cnt_q);
        else
            cnt_d = cnt_q;

        run_cnt_d = de_in ? sat_inc12(run_cnt_q) : 12'd0;
        discard_d = vs_rise ? de_in : (de_in & discard_q);

        if (vs_rise)
            err_d = 1'b0;
        else if (state_q == RUN && de_prev_q && !de_in && !discard_q
                 && run_cnt_q != 12'(H_SIZE))
            err_d = 1'b1;
        else
            err_d = err_q;

        pub_p1_d = vs_rise & (state_q == RUN);
`ifdef GRADIENT_RENDER_HEATMAP_EN
        heat_p1_d = squared_modulus_in[16:9];
`else
        heat_p1_d = 8'd0;
`endif

        if (!de_p1_q)
            rgb_d = 24'd0;
        else if (edge_p1_q)
            rgb_d = xdom_p1_q ? 24'hFF0000 : 24'h00FF00;
        else
            rgb_d = {3{heat_p1_q}};

        edge_count_d = pub_p1_q ? pcnt_p1_q : edge_count_q;
        line_err_d   = pub_p1_q ? perr_p1_q : line_err_q;
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_SYNC;
            thr_q        <= THRESHOLD_DEFAULT;
            vs_prev_q    <= 1'b0;
            de_prev_q    <= 1'b0;
            cnt_q        <= 16'd0;
            run_cnt_q    <= 12'd0;
            discard_q    <= 1'b0;
            err_q        <= 1'b0;
            de_p1_q      <= 1'b0;
            hs_p1_q      <= 1'b0;
            vs_p1_q      <= 1'b0;
            edge_p1_q    <= 1'b0;
            xdom_p1_q    <= 1'b0;
            heat_p1_q    <= 8'd0;
            pub_p1_q     <= 1'b0;
            pcnt_p1_q    <= 16'd0;
            perr_p1_q    <= 1'b0;
            de_out_q     <= 1'b0;
            hs_out_q     <= 1'b0;
            vs_out_q     <= 1'b0;
            rgb_q        <= 24'd0;
            frame_done_q <= 1'b0;
            edge_count_q <= 16'd0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            thr_q        <= thr_d;
            vs_prev_q    <= vsync_in;
            de_prev_q    <= de_in;
            cnt_q        <= cnt_d;
            run_cnt_q    <= run_cnt_d;
            discard_q    <= discard_d;
            err_q        <= err_d;
            // stage 1: abs, compare, edge decision, boundary snapshot
            de_p1_q      <= de_in;
            hs_p1_q      <= hsync_in;
            vs_p1_q      <= vsync_in;
            edge_p1_q    <= is_edge;
            xdom_p1_q    <= x_dom;
            heat_p1_q    <= heat_p1_d;
            pub_p1_q     <= pub_p1_d;
            pcnt_p1_q    <= cnt_q;
            perr_p1_q    <= err_q;
            // stage 2: colour mux and statistics publish
            de_out_q     <= de_p1_q;
            hs_out_q     <= hs_p1_q;
            vs_out_q     <= vs_p1_q;
            rgb_q        <= rgb_d;
            frame_done_q <= pub_p1_q;
            edge_count_q <= edge_count_d;
            line_err_q   <= line_err_d;
        end
    end

    assign de_out     = de_out_q;
    assign hsync_out  = hs_out_q;
    assign vsync_out  = vs_out_q;
    assign pixel_r    = rgb_q[23:16];
    assign pixel_g    = rgb_q[15:8];
    assign pixel_b    = rgb_q[7:0];
    assign frame_done = frame_done_q;
    assign edge_count = edge_count_q;
    assign line_err   = line_err_q;

endmodule
